// File: rtl/systolic_ctrl.sv
// systolic_ctrl: tile sequencer on the driving side of the systolic MAC array.
// Feeds weight/data SRAM read addresses and alu_start/cycle_num through one
// tile computation, then drains the array one result row at a time over a
// valid/ready interface towards the output-buffer writer.
//
// Ports:
//   clk, srst                  clock, synchronous active-high reset
//   start, rd_base, wr_base    tile request and its base addresses
//   busy, done                 tile in flight / one-cycle completion pulse
//   sram_raddr_w/_d            weight/data SRAM read address (identical)
//   alu_start, cycle_num       array enable and compute cycle index
//   matrix_index, mul_outcome  array row select and its combinational result
//   out_valid/out_ready        result row handshake
//   out_data, out_addr         registered result row and its write address
//
// Build option: define SYSTOLIC_CTRL_RELU_EN to clamp negative lanes of each
// captured row to zero (timing is identical in both builds).
module systolic_ctrl #(
  parameter int unsigned ARRAY_SIZE    = 16,
  parameter int unsigned OUTCOME_WIDTH = 29,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned FEED_LEN      = 16,
  parameter int unsigned CYCLE_LAST    = 48
) (
  input  logic                                clk,
  input  logic                                srst,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               rd_base,
  input  logic [ADDR_WIDTH-1:0]               wr_base,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_WIDTH-1:0]               sram_raddr_w,
  output logic [ADDR_WIDTH-1:0]               sram_raddr_d,
  output logic                                alu_start,
  output logic [8:0]                          cycle_num,
  output logic [5:0]                          matrix_index,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]               out_addr
);

  localparam int unsigned DATA_W = ARRAY_SIZE * OUTCOME_WIDTH;
  localparam int unsigned ROW_W  = $clog2(ARRAY_SIZE + 1);

  typedef enum logic [1:0] {IDLE, PRE, FEED, DRAIN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   rd_base_q;
  logic [ADDR_WIDTH-1:0]   wr_base_q;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [ROW_W-1:0]        row_cnt;     // rows captured so far in DRAIN
  logic [DATA_W-1:0]       capture_data;
  logic                    all_captured;

  // Both SRAMs are read at the same address from one register.
  assign sram_raddr_w = raddr_q;
  assign sram_raddr_d = raddr_q;

  assign all_captured = (row_cnt == ROW_W'(ARRAY_SIZE));

  // Row value as it will be registered into out_data.
  always_comb begin
    capture_data = mul_outcome;
`ifdef SYSTOLIC_CTRL_RELU_EN
    for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
      if (mul_outcome[i*OUTCOME_WIDTH + OUTCOME_WIDTH - 1]) begin
        capture_data[i*OUTCOME_WIDTH +: OUTCOME_WIDTH] = '0;
      end
    end
`endif
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= IDLE;
      rd_base_q    <= '0;
      wr_base_q    <= '0;
      raddr_q      <= '0;
      row_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      alu_start    <= 1'b0;
      cycle_num    <= '0;
      matrix_index <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_addr     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done) begin
            rd_base_q <= rd_base;
            wr_base_q <= wr_base;
            raddr_q   <= rd_base;
            busy      <= 1'b1;
            state     <= PRE;
          end
        end
        PRE: begin
          // Data for rd_base arrives together with the first FEED cycle.
          raddr_q   <= raddr_q + ADDR_WIDTH'(1);
          alu_start <= 1'b1;
          cycle_num <= '0;
          state     <= FEED;
        end
        FEED: begin
          cycle_num <= cycle_num + 9'd1;
          if (raddr_q != rd_base_q + ADDR_WIDTH'(FEED_LEN - 1)) begin
            raddr_q <= raddr_q + ADDR_WIDTH'(1);
          end
          if (cycle_num == 9'(CYCLE_LAST)) begin
            alu_start    <= 1'b0;
            cycle_num    <= cycle_num;
            matrix_index <= '0;
            row_cnt      <= '0;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && all_captured) begin
            // Last row handed over: close the tile.
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_addr     <= '0;
            done         <= 1'b1;
            busy         <= 1'b0;
            cycle_num    <= '0;
            matrix_index <= '0;
            raddr_q      <= '0;
            row_cnt      <= '0;
            state        <= IDLE;
          end else if ((!out_valid || out_ready) && !all_captured) begin
            // One-deep output register: refill when empty or being drained.
            out_data  <= capture_data;
            out_addr  <= wr_base_q + ADDR_WIDTH'(row_cnt);
            out_valid <= 1'b1;
            row_cnt   <= row_cnt + ROW_W'(1);
            if (row_cnt != ROW_W'(ARRAY_SIZE - 1)) begin
              matrix_index <= matrix_index + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
